// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI types and constants
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  // Mode 0 is shared with the slave bridge on the other end of the link.
  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    NEXT,
    HOLD
  } spi_mst_state_t;

endpackage

// File: rtl/spi_sclk_div.sv
// rtl/spi_sclk_div.sv - sclk half-period divider with rise/fall strobes
module spi_sclk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick_rise,
  output logic tick_fall,
  output logic sclk
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             term;

  // Strobes are asserted in the cycle whose closing edge toggles sclk.
  always_comb begin
    term      = en && (cnt_q == CNT_LAST);
    tick_rise = term && !sclk_q;
    tick_fall = term && sclk_q;
    cnt_d     = cnt_q;
    sclk_d    = sclk_q;
    if (clr) begin
      cnt_d  = '0;
      sclk_d = SPI_CPOL;
    end else if (en) begin
      if (term) begin
        cnt_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= SPI_CPOL;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - mode 0 SPI master with byte-stream front end
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_valid,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_last,
  output logic                  tx_ready,
  output logic                  rx_valid,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  busy,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int CS_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CS_W   = (CS_MAX > 1) ? $clog2(CS_MAX) : 1;
  localparam logic [CS_W-1:0] SETUP_LAST = CS_W'(CS_SETUP - 1);
  localparam logic [CS_W-1:0] HOLD_LAST  = CS_W'(CS_HOLD - 1);
  localparam bit SAMPLE_ON_RISE = (SPI_CPOL == SPI_CPHA);

  spi_mst_state_t state_q, state_d;

  logic [SPI_BYTE_W-1:0] shift_tx_q, shift_tx_d;
  logic [SPI_BYTE_W-1:0] shift_rx_q, shift_rx_d;
  logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [CS_W-1:0]       cs_cnt_q, cs_cnt_d;
  logic                  last_q, last_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  busy_q, busy_d;
  logic                  cs_n_q, cs_n_d;
  logic                  mosi_q, mosi_d;

  logic div_en, div_clr, tick_rise, tick_fall;
  logic sample_tick, shift_tick, accept, byte_end;

  assign div_en      = (state_q == XFER);
  assign div_clr     = !div_en;
  assign sample_tick = SAMPLE_ON_RISE ? tick_rise : tick_fall;
  assign shift_tick  = SAMPLE_ON_RISE ? tick_fall : tick_rise;
  assign accept      = tx_valid && tx_ready_q;
  assign byte_end    = div_en && shift_tick && (bit_cnt_q == 3'd7);

  spi_sclk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_div (
    .clk      (clk),
    .rst      (rst),
    .clr      (div_clr),
    .en       (div_en),
    .tick_rise(tick_rise),
    .tick_fall(tick_fall),
    .sclk     (sclk)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   if (cs_cnt_q == SETUP_LAST) state_d = XFER;
      XFER:    if (byte_end) state_d = last_q ? HOLD : NEXT;
      NEXT:    if (accept) state_d = XFER;
      HOLD:    if (cs_cnt_q == HOLD_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags track the state being entered so they line up with state_q.
  always_comb begin
    shift_tx_d = shift_tx_q;
    shift_rx_d = shift_rx_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    last_d     = last_q;
    rx_valid_d = 1'b0;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    tx_ready_d = (state_d == IDLE) || (state_d == NEXT);
    busy_d     = (state_d != IDLE);
    cs_cnt_d   = ((state_q == SETUP || state_q == HOLD) && state_d == state_q)
                 ? cs_cnt_q + 1'b1 : '0;
    case (state_q)
      IDLE, NEXT: begin
        if (accept) begin
          shift_tx_d = tx_data;
          last_d     = tx_last;
          mosi_d     = tx_data[SPI_BYTE_W-1];
          cs_n_d     = 1'b0;
          bit_cnt_d  = 3'd0;
        end
      end
      XFER: begin
        if (sample_tick) begin
          shift_rx_d = {shift_rx_q[SPI_BYTE_W-2:0], miso};
        end
        if (shift_tick) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q != 3'd7) begin
            shift_tx_d = {shift_tx_q[SPI_BYTE_W-2:0], 1'b0};
            mosi_d     = shift_tx_q[SPI_BYTE_W-2];
          end else begin
            rx_valid_d = 1'b1;
            rx_data_d  = shift_rx_q;
          end
        end
      end
      HOLD: begin
        if (state_d == IDLE) begin
          cs_n_d = 1'b1;
          mosi_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_tx_q <= '0;
      shift_rx_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      cs_cnt_q   <= '0;
      last_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      shift_tx_q <= shift_tx_d;
      shift_rx_q <= shift_rx_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      cs_cnt_q   <= cs_cnt_d;
      last_q     <= last_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = busy_q;
  assign cs_n     = cs_n_q;
  assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - directed bench for spi_master_ctrl
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;

  logic       miso_loop;
  logic [7:0] slave_sr;

  int total = 0;
  int bad   = 0;

  logic [7:0]  f_tx [8];
  logic [7:0]  f_rx [8];
  int          f_rises, f_rx_n, f_cs_fall_n, f_rx0_n, f_last_fall_n, f_cs_rise_n;
  logic [31:0] f_bits;
  logic        f_mosi_glitch, f_timeout;

  always #5 clk = ~clk;

  spi_master_ctrl #(
    .CLK_DIV (2),
    .CS_SETUP(2),
    .CS_HOLD (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_last (tx_last),
    .tx_ready(tx_ready),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .busy    (busy),
    .sclk    (sclk),
    .cs_n    (cs_n),
    .mosi    (mosi),
    .miso    (miso)
  );

  // Mode 0 slave: MSB presented at cs_n fall, next bit after every sclk fall.
  assign miso = miso_loop ? mosi : slave_sr[7];
  always @(negedge sclk) begin
    if (!miso_loop && !cs_n) slave_sr = {slave_sr[6:0], 1'b0};
  end

  task automatic run_frame(input int nb);
    int idx, n;
    logic acc, prev_sclk, prev_cs, prev_mosi;
    f_rises = 0; f_rx_n = 0; f_cs_fall_n = -1; f_rx0_n = -1;
    f_last_fall_n = -1; f_cs_rise_n = -1; f_bits = '0;
    f_mosi_glitch = 1'b0; f_timeout = 1'b1;
    idx = 0;
    tx_valid = 1'b1; tx_data = f_tx[0]; tx_last = (nb == 1);
    acc = tx_valid && tx_ready;
    prev_sclk = sclk; prev_cs = cs_n; prev_mosi = mosi;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      if (prev_cs && !cs_n && f_cs_fall_n < 0) f_cs_fall_n = n;
      if (!prev_sclk && sclk) begin
        f_rises++;
        f_bits = {f_bits[30:0], mosi};
      end
      if (prev_sclk && !sclk) f_last_fall_n = n;
      if (sclk && mosi !== prev_mosi) f_mosi_glitch = 1'b1;
      if (rx_valid) begin
        if (f_rx_n < 8) f_rx[f_rx_n] = rx_data;
        if (f_rx_n == 0) f_rx0_n = n;
        f_rx_n++;
      end
      if (acc) begin
        idx++;
        if (idx < nb) begin
          tx_data = f_tx[idx];
          tx_last = (idx == nb - 1);
        end else begin
          tx_valid = 1'b0;
        end
      end
      acc = tx_valid && tx_ready;
      if (!prev_cs && cs_n) begin
        f_cs_rise_n = n;
        f_timeout = 1'b0;
        break;
      end
      prev_sclk = sclk; prev_cs = cs_n; prev_mosi = mosi;
    end
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic ok;
    logic [4:0] seen;
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (cs_n !== 1'b1)     begin bad++; $display("FAIL reset_cs_n got=%b want=1", cs_n); end
    total++; if (sclk !== 1'b0)     begin bad++; $display("FAIL reset_sclk got=%b want=0", sclk); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL reset_tx_ready got=%b want=0", tx_ready); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
    total++; if (mosi !== 1'b0)     begin bad++; $display("FAIL reset_mosi got=%b want=0", mosi); end
    rst = 1'b0;
    ok = 1'b1; seen = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ok && (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0 ||
                 tx_ready !== 1'b1 || rx_valid !== 1'b0)) begin
        ok = 1'b0;
        seen = {cs_n, sclk, busy, tx_ready, rx_valid};
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL idle_outputs got cs_n,sclk,busy,tx_ready,rx_valid=%b want=10010", seen);
    end
  endtask

  task automatic test_single_byte();
    miso_loop = 1'b0; slave_sr = 8'h3C;
    f_tx[0] = 8'hA5;
    run_frame(1);
    total++; if (f_timeout)          begin bad++; $display("FAIL single_timeout cs_n never rose"); end
    total++; if (f_rises != 8)       begin bad++; $display("FAIL single_rises got=%0d want=8", f_rises); end
    total++; if (f_bits[7:0] !== 8'hA5) begin bad++; $display("FAIL single_mosi_bits got=%h want=a5", f_bits[7:0]); end
    total++; if (f_mosi_glitch)      begin bad++; $display("FAIL single_mosi_stable got=changed_while_sclk_high want=stable"); end
    total++; if (f_rx_n != 1)        begin bad++; $display("FAIL single_rx_count got=%0d want=1", f_rx_n); end
    total++; if (f_rx[0] !== 8'h3C)  begin bad++; $display("FAIL single_rx_data got=%h want=3c", f_rx[0]); end
    // CS_SETUP cycles to the first half-period start, then 16 half-periods of 2 clk.
    total++; if (f_rx0_n - f_cs_fall_n != 34) begin bad++; $display("FAIL single_rx_latency got=%0d want=34", f_rx0_n - f_cs_fall_n); end
    total++; if (f_cs_rise_n - f_last_fall_n != 2) begin bad++; $display("FAIL single_cs_hold got=%0d want=2", f_cs_rise_n - f_last_fall_n); end
  endtask

  task automatic test_back_to_back();
    miso_loop = 1'b1;
    f_tx[0] = 8'h01; f_tx[1] = 8'h02; f_tx[2] = 8'h03;
    run_frame(3);
    total++; if (f_timeout)     begin bad++; $display("FAIL frame_timeout cs_n never rose"); end
    total++; if (f_rises != 24) begin bad++; $display("FAIL frame_rises got=%0d want=24", f_rises); end
    total++; if (f_rx_n != 3)   begin bad++; $display("FAIL frame_rx_count got=%0d want=3", f_rx_n); end
    total++; if (f_rx[0] !== 8'h01) begin bad++; $display("FAIL frame_rx0 got=%h want=01", f_rx[0]); end
    total++; if (f_rx[1] !== 8'h02) begin bad++; $display("FAIL frame_rx1 got=%h want=02", f_rx[1]); end
    total++; if (f_rx[2] !== 8'h03) begin bad++; $display("FAIL frame_rx2 got=%h want=03", f_rx[2]); end
  endtask

  task automatic test_stall_next();
    int n;
    logic ok, got;
    logic [2:0] seen;
    miso_loop = 1'b1;
    tx_valid = 1'b1; tx_data = 8'h5A; tx_last = 1'b0;
    @(negedge clk);
    tx_valid = 1'b0;
    got = 1'b0;
    for (n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (rx_valid) got = 1'b1;
    end
    total++; if (!got) begin bad++; $display("FAIL stall_rx1_timeout no rx_valid"); end
    total++; if (rx_data !== 8'h5A) begin bad++; $display("FAIL stall_rx1_data got=%h want=5a", rx_data); end
    ok = 1'b1; seen = '0;
    for (int i = 0; i < 50; i++) begin
      if (ok && (sclk !== 1'b0 || cs_n !== 1'b0 || tx_ready !== 1'b1)) begin
        ok = 1'b0;
        seen = {sclk, cs_n, tx_ready};
      end
      @(negedge clk);
    end
    total++; if (!ok) begin bad++; $display("FAIL stall_hold got sclk,cs_n,tx_ready=%b want=001", seen); end
    tx_valid = 1'b1; tx_data = 8'hC3; tx_last = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    got = 1'b0;
    for (n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (rx_valid) got = 1'b1;
    end
    total++; if (!got) begin bad++; $display("FAIL stall_rx2_timeout no rx_valid"); end
    total++; if (rx_data !== 8'hC3) begin bad++; $display("FAIL stall_rx2_data got=%h want=c3", rx_data); end
    got = 1'b0;
    for (n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (cs_n) got = 1'b1;
    end
    total++; if (!got) begin bad++; $display("FAIL stall_cs_release got=cs_n_low want=cs_n_high"); end
  endtask

  task automatic test_reset_mid_frame();
    int n, rises;
    logic prev_sclk, spurious;
    miso_loop = 1'b1;
    tx_valid = 1'b1; tx_data = 8'hFF; tx_last = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    rises = 0; prev_sclk = sclk;
    for (n = 0; n < 200 && rises < 4; n++) begin
      @(negedge clk);
      if (!prev_sclk && sclk) rises++;
      prev_sclk = sclk;
    end
    total++; if (rises != 4) begin bad++; $display("FAIL abort_reach_bit4 got=%0d rises want=4", rises); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (cs_n !== 1'b1)     begin bad++; $display("FAIL abort_cs_n got=%b want=1", cs_n); end
    total++; if (sclk !== 1'b0)     begin bad++; $display("FAIL abort_sclk got=%b want=0", sclk); end
    total++; if (mosi !== 1'b0)     begin bad++; $display("FAIL abort_mosi got=%b want=0", mosi); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    rst = 1'b0;
    spurious = rx_valid;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rx_valid) spurious = 1'b1;
    end
    total++; if (spurious) begin bad++; $display("FAIL abort_rx_valid got=1 want=0"); end
    f_tx[0] = 8'h55;
    run_frame(1);
    total++; if (f_timeout || f_rx_n != 1) begin bad++; $display("FAIL after_abort_rx_count got=%0d want=1", f_rx_n); end
    total++; if (f_rx[0] !== 8'h55) begin bad++; $display("FAIL after_abort_rx_data got=%h want=55", f_rx[0]); end
    total++; if (f_bits[7:0] !== 8'h55) begin bad++; $display("FAIL after_abort_mosi got=%h want=55", f_bits[7:0]); end
  endtask

  task automatic test_loopback_random();
    miso_loop = 1'b1;
    for (int i = 0; i < 5; i++) f_tx[i] = 8'($urandom_range(0, 255));
    run_frame(5);
    total++; if (f_timeout || f_rx_n != 5) begin bad++; $display("FAIL loop_rx_count got=%0d want=5", f_rx_n); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (f_rx[i] !== f_tx[i]) begin
        bad++;
        $display("FAIL loop_byte%0d got=%h want=%h", i, f_rx[i], f_tx[i]);
      end
    end
  endtask

  initial begin
    miso_loop = 1'b0;
    slave_sr  = 8'h00;
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
    test_reset();
    test_single_byte();
    repeat (3) @(negedge clk);
    test_back_to_back();
    repeat (3) @(negedge clk);
    test_stall_next();
    repeat (3) @(negedge clk);
    test_reset_mid_frame();
    repeat (3) @(negedge clk);
    test_loopback_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
